// File: rtl/cvxif_result_queue.sv
// Result queue between an execution group and the core: a circular FIFO of {id, data} plus an rd/we lookup table.
// Optional macro CVXIF_RESULT_BYPASS_EN lets a result reach the core in the cycle it completes when the FIFO is empty.
module cvxif_result_queue #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 issue_vld_i,
  input  logic [IdWidth-1:0]   issue_id_i,
  input  logic [4:0]           issue_rd_i,
  input  logic                 issue_we_i,
  input  logic                 done_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [IdWidth-1:0]   id_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [IdWidth-1:0]   result_id_o,
  output logic [DataWidth-1:0] result_data_o,
  output logic [4:0]           result_rd_o,
  output logic                 result_we_o,
  output logic                 stall_o,
  output logic                 overflow_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned NumIds = 2 ** IdWidth;

  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [IdWidth-1:0]   id_mem_q   [Depth];
  logic [IdWidth-1:0]   id_mem_d   [Depth];
  logic [DataWidth-1:0] data_mem_q [Depth];
  logic [DataWidth-1:0] data_mem_d [Depth];
  logic [5:0]           rd_table_q [NumIds];
  logic [5:0]           rd_table_d [NumIds];

  logic full, empty, pop, fifo_pop, push, drop;

  always_comb begin
    full           = (count_q == CntW'(Depth));
    empty          = (count_q == '0);
    result_valid_o = !empty;
    result_id_o    = id_mem_q[rd_ptr_q];
    result_data_o  = data_mem_q[rd_ptr_q];
`ifdef CVXIF_RESULT_BYPASS_EN
    if (empty) begin
      result_valid_o = done_i;
      result_id_o    = id_i;
      result_data_o  = data_i;
    end
`endif
    pop      = result_valid_o && result_ready_i;
    fifo_pop = pop && !empty;
    push     = done_i && (!full || pop);
`ifdef CVXIF_RESULT_BYPASS_EN
    // A bypassed result the core takes immediately never enters the FIFO.
    if (empty && pop) begin
      push = 1'b0;
    end
`endif
    drop        = done_i && full && !pop;
    overflow_o  = overflow_q;
    stall_o     = (count_q >= CntW'(Depth - 1)) ||
                  ((count_q == CntW'(Depth - 2)) && done_i && !pop);
    // Table is read from the registered copy, so a same-cycle issue write returns the old value.
    result_rd_o = rd_table_q[result_id_o][5:1];
    result_we_o = rd_table_q[result_id_o][0];
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    id_mem_d   = id_mem_q;
    data_mem_d = data_mem_q;
    rd_table_d = rd_table_q;
    if (issue_vld_i) begin
      rd_table_d[issue_id_i] = {issue_rd_i, issue_we_i};
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        id_mem_d[wr_ptr_q]   = id_i;
        data_mem_d[wr_ptr_q] = data_i;
        wr_ptr_d             = wr_ptr_q + PtrW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, fifo_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage arrays carry no reset; valid-ness comes only from the count.
  always_ff @(posedge clk_i) begin
    id_mem_q   <= id_mem_d;
    data_mem_q <= data_mem_d;
    rd_table_q <= rd_table_d;
  end

endmodule

// File: tb/tb_cvxif_result_queue.sv
// Self-checking bench for cvxif_result_queue: directed scenarios then random traffic against a queue-based model.
// Honours CVXIF_RESULT_BYPASS_EN so the same bench fits either build.
module tb_cvxif_result_queue;

  localparam int DW    = 32;
  localparam int IW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, issue_vld, issue_we, done, ready;
  logic [IW-1:0] issue_id, id_in;
  logic [4:0]    issue_rd;
  logic [DW-1:0] data_in;

  logic          valid_o, we_o, stall_o, ovf_o;
  logic [IW-1:0] id_o;
  logic [DW-1:0] data_o;
  logic [4:0]    rd_o;

  int vectors    = 0;
  int miscompares = 0;

  logic [IW-1:0] m_id[$];
  logic [DW-1:0] m_data[$];
  logic [5:0]    m_tbl[2**IW];
  bit            m_ovf;
  bit            e_valid, e_pop;

  always #5 clk = ~clk;

  cvxif_result_queue #(.DataWidth(DW), .IdWidth(IW), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_vld_i(issue_vld), .issue_id_i(issue_id), .issue_rd_i(issue_rd), .issue_we_i(issue_we),
    .done_i(done), .data_i(data_in), .id_i(id_in),
    .result_valid_o(valid_o), .result_ready_i(ready), .result_id_o(id_o),
    .result_data_o(data_o), .result_rd_o(rd_o), .result_we_o(we_o),
    .stall_o(stall_o), .overflow_o(ovf_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every output against the model mid-cycle, before the next rising edge.
  task automatic check_output();
    bit            empty;
    logic [IW-1:0] e_id;
    logic [DW-1:0] e_data;
    int            cnt;
    @(negedge clk);
    cnt     = m_id.size();
    empty   = (cnt == 0);
    e_valid = rst_n && !empty;
    e_id    = empty ? '0 : m_id[0];
    e_data  = empty ? '0 : m_data[0];
`ifdef CVXIF_RESULT_BYPASS_EN
    if (rst_n && empty) begin
      e_valid = done;
      e_id    = id_in;
      e_data  = data_in;
    end
`endif
    e_pop = e_valid && ready;
    chk("valid", 64'(valid_o), 64'(e_valid));
    if (e_valid) begin
      chk("id",   64'(id_o),   64'(e_id));
      chk("data", 64'(data_o), 64'(e_data));
      chk("rd",   64'(rd_o),   64'(m_tbl[e_id][5:1]));
      chk("we",   64'(we_o),   64'(m_tbl[e_id][0]));
    end
    chk("stall", 64'(stall_o),
        64'((cnt >= DEPTH - 1) || (cnt == DEPTH - 2 && done && !e_pop)));
    chk("overflow", 64'(ovf_o), 64'(m_ovf));
  endtask

  task automatic advance();
    bit full, empty, push;
    @(posedge clk);
    if (rst_n) begin
      empty = (m_id.size() == 0);
      full  = (m_id.size() == DEPTH);
      push  = done && (!full || e_pop);
`ifdef CVXIF_RESULT_BYPASS_EN
      if (empty && e_pop) push = 1'b0;
`endif
      if (done && full && !e_pop) m_ovf = 1'b1;
      if (flush) begin
        m_id.delete();
        m_data.delete();
      end else begin
        if (e_pop && !empty) begin
          void'(m_id.pop_front());
          void'(m_data.pop_front());
        end
        if (push) begin
          m_id.push_back(id_in);
          m_data.push_back(data_in);
        end
      end
      if (issue_vld) m_tbl[issue_id] = {issue_rd, issue_we};
    end
    #1;
  endtask

  task automatic step();
    check_output();
    advance();
  endtask

  task automatic push_result(input logic [IW-1:0] id, input logic [DW-1:0] d);
    done = 1'b1; id_in = id; data_in = d;
    step();
    done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_vld = 1'b0; issue_we = 1'b0; issue_id = '0; issue_rd = '0;
    done = 1'b0; ready = 1'b0; id_in = '0; data_in = '0; m_ovf = 1'b0;

    check_output();
    chk("reset_valid", 64'(valid_o), 64'(0));
    chk("reset_stall", 64'(stall_o), 64'(0));
    advance();
    rst_n = 1'b1;

    for (int i = 0; i < 2**IW; i++) begin
      issue_vld = 1'b1; issue_id = IW'(i); issue_rd = 5'($urandom); issue_we = 1'($urandom);
      step();
    end
    issue_vld = 1'b0;

    // Single result with its destination looked up from the table.
    issue_vld = 1'b1; issue_id = 3'd2; issue_rd = 5'd7; issue_we = 1'b1;
    step();
    issue_vld = 1'b0;
    ready = 1'b1; done = 1'b1; id_in = 3'd2; data_in = 32'hDEADBEEF;
    check_output();
`ifdef CVXIF_RESULT_BYPASS_EN
    chk("byp_valid", 64'(valid_o), 64'(1));
    chk("byp_data", 64'(data_o), 64'(32'hDEADBEEF));
    advance();
    done = 1'b0;
`else
    chk("lat_valid0", 64'(valid_o), 64'(0));
    advance();
    done = 1'b0;
    check_output();
    chk("r41_valid", 64'(valid_o), 64'(1));
    chk("r41_rd", 64'(rd_o), 64'(7));
    chk("r41_we", 64'(we_o), 64'(1));
    chk("r41_data", 64'(data_o), 64'(32'hDEADBEEF));
    advance();
`endif
    check_output();
    chk("r41_popped", 64'(valid_o), 64'(0));
    advance();

    // Four pushes without acceptance, then in-order drain.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      done = 1'b1; id_in = IW'(i); data_in = $urandom;
      check_output();
      if (i == 2) chk("stall_third", 64'(stall_o), 64'(1));
      advance();
    end
    done = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_output();
      chk("order", 64'(id_o), 64'(i));
      advance();
    end

    // Full FIFO: drop without pop, no drop with a simultaneous pop.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push_result(IW'(i + 4), $urandom);
    push_result(3'd1, 32'h0BAD0BAD);
    check_output();
    chk("ovf_set", 64'(ovf_o), 64'(1));
    chk("ovf_head", 64'(id_o), 64'(4));
    advance();
    ready = 1'b1;
    push_result(3'd6, $urandom);
    ready = 1'b0;
    check_output();
    chk("full_kept", 64'(stall_o), 64'(1));
    advance();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Flush overrides a same-cycle push.
    ready = 1'b0;
    push_result(3'd3, $urandom);
    push_result(3'd4, $urandom);
    flush = 1'b1; done = 1'b1; id_in = 3'd5; data_in = $urandom;
    step();
    flush = 1'b0; done = 1'b0;
    check_output();
    chk("flush_valid", 64'(valid_o), 64'(0));
    chk("flush_stall", 64'(stall_o), 64'(0));
    advance();

    // Reset while a result is offered but not accepted.
    push_result(3'd7, $urandom);
    check_output();
    advance();
    #2 rst_n = 1'b0;
    m_id.delete(); m_data.delete(); m_ovf = 1'b0;
    check_output();
    advance();
    rst_n = 1'b1;
    check_output();
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_ovf", 64'(ovf_o), 64'(0));
    advance();

    // Result latency from an empty FIFO.
    ready = 1'b1; done = 1'b1; id_in = 3'd5; data_in = $urandom;
    check_output();
`ifdef CVXIF_RESULT_BYPASS_EN
    chk("b46_valid", 64'(valid_o), 64'(1));
    chk("b46_id", 64'(id_o), 64'(5));
`else
    chk("b46_valid", 64'(valid_o), 64'(0));
`endif
    advance();
    done = 1'b0;
    check_output();
`ifdef CVXIF_RESULT_BYPASS_EN
    chk("b46_empty", 64'(valid_o), 64'(0));
`else
    chk("b46_late", 64'(valid_o), 64'(1));
    chk("b46_id", 64'(id_o), 64'(5));
`endif
    advance();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(24) == 0);
      done      = !flush && ($urandom_range(2) != 0);
      id_in     = IW'($urandom);
      data_in   = $urandom;
      ready     = 1'($urandom);
      issue_vld = 1'($urandom);
      issue_id  = IW'($urandom);
      issue_rd  = 5'($urandom);
      issue_we  = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cvxif_result_queue.md
CVXIF_RESULT_QUEUE -- requirements
Module: cvxif_result_queue

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning result data width.
REQ-002 SHALL have parameter IdWidth, default 3, meaning instruction id width; the rd table holds 2**IdWidth entries.
REQ-003 SHALL have parameter Depth, default 4, meaning queue entries; power of two, at least 2.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port flush_i, input, 1, synchronous clear of queue contents.
REQ-007 SHALL have port issue_vld_i, input, 1, an accepted instruction's destination is recorded this cycle.
REQ-008 SHALL have port issue_id_i, input, IdWidth, id of the issued instruction.
REQ-009 SHALL have port issue_rd_i, input, 5, destination register of the issued instruction.
REQ-010 SHALL have port issue_we_i, input, 1, issued instruction writes rd.
REQ-011 SHALL have port done_i, input, 1, execution-group result valid; no backpressure upstream.
REQ-012 SHALL have port data_i, input, DataWidth, result data qualified by done_i.
REQ-013 SHALL have port id_i, input, IdWidth, result instruction id qualified by done_i.
REQ-014 SHALL have port result_valid_o, output, 1, result offered to core.
REQ-015 SHALL have port result_ready_i, input, 1, core accepts the offered result.
REQ-016 SHALL have port result_id_o, output, IdWidth, id of the offered result.
REQ-017 SHALL have port result_data_o, output, DataWidth, data of the offered result.
REQ-018 SHALL have port result_rd_o, output, 5, rd of the offered result, looked up from the rd table.
REQ-019 SHALL have port result_we_o, output, 1, we of the offered result, looked up from the rd table.
REQ-020 SHALL have port stall_o, output, 1, upstream must stop issuing.
REQ-021 SHALL have port overflow_o, output, 1, sticky error: a result was dropped.

Function
REQ-022 SHALL push {id_i, data_i} into a circular FIFO when done_i=1 and the FIFO is not full, or when it is full and a pop occurs the same cycle.
REQ-023 SHALL pop the head entry when result_valid_o=1 and result_ready_i=1.
REQ-024 SHALL leave the occupancy count unchanged on a simultaneous push and pop, including at full and at one entry.
REQ-025 SHALL wrap the read and write pointers modulo Depth; the full and empty conditions come from a count of width log2(Depth)+1.
REQ-026 SHALL drive result_valid_o=1 exactly when the FIFO is non-empty (bypass rules excepted); result_id_o and result_data_o come from the head entry.
REQ-027 SHALL hold the head entry stable while result_valid_o=1 and result_ready_i=0.
REQ-028 SHALL give result latency: done_i in cycle N makes the entry visible in cycle N+1 when the FIFO was empty.
REQ-029 SHALL write rd_table[issue_id_i] <= {issue_rd_i, issue_we_i} on issue_vld_i=1.
REQ-030 SHALL drive result_rd_o and result_we_o combinationally as rd_table[result_id_o].
REQ-031 SHALL, when an issue write and a head read target the same id in one cycle, return the old table value.
REQ-032 SHALL assert stall_o when count >= Depth-1, or when count = Depth-2 and done_i=1 with no pop.
REQ-033 SHALL, on done_i with the FIFO full and no pop, drop the entry, set overflow_o, and leave the FIFO unchanged.
REQ-034 SHALL, on flush_i, empty the FIFO next cycle; it overrides a same-cycle push and pop, and leaves overflow_o and the rd table untouched.

Reset
REQ-035 SHALL, while rst_ni=0, clear the pointers, the count and overflow_o, so that result_valid_o=0 and stall_o=0.
REQ-036 SHALL not reset the FIFO data or the rd table.
REQ-037 SHALL abandon an entry offered when reset asserts mid-handshake; no result follows reset release.

Configuration
REQ-038 SHALL, with macro CVXIF_RESULT_BYPASS_EN defined and the FIFO empty, drive result_valid_o=done_i and the result outputs from id_i/data_i in the same cycle.
REQ-039 SHALL, with CVXIF_RESULT_BYPASS_EN defined, not push a bypassed result that is accepted in that cycle; one not accepted is pushed normally.
REQ-040 SHALL, without CVXIF_RESULT_BYPASS_EN, apply only the REQ-028 one-cycle latency.

Verification
REQ-041 SHALL cover: issue id=2, rd=7, we=1; then done_i id=2, data=0xDEADBEEF; ready=1 -> next cycle valid=1, rd=7, we=1, data 0xDEADBEEF, popped once.
REQ-042 SHALL cover: ready=0, four done_i pushes (ids 0-3) -> stall_o=1 from the third push; then ready=1 -> results in order 0,1,2,3.
REQ-043 SHALL cover: FIFO full, done_i with ready=0 -> overflow_o=1, contents unchanged; the same with ready=1 -> no overflow, count stays 4.
REQ-044 SHALL cover: two entries queued, flush_i together with done_i -> next cycle valid=0, count 0.
REQ-045 SHALL cover: rst_ni low while valid=1 with ready=0 -> valid=0 and overflow_o=0 after release.
REQ-046 SHALL cover: with bypass, FIFO empty, done_i id=5 and ready=1 -> valid the same cycle, FIFO stays empty; without bypass, valid one cycle later.
